// File: rtl/top_robertsons.sv
// Sequential signed multiplier using Robertson's add/shift algorithm.
// Performs one N-cycle multiply after each reset release, then holds the product with done high.
module top_robertsons #(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     multiplier,
   input  logic [N-1:0]     multiplicand,
   output logic [2*N-1:0]   product,
   output logic             done
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [N-1:0]     a_r;
   logic [N-1:0]     q_r;
   logic [N-1:0]     m_r;
   logic [CW-1:0]    count_r;
   logic [2*N-1:0]   product_r;
   logic             done_r;
   logic [N:0]       sum_s;
   logic             last_step_s;

   function automatic logic [N:0] sext(input logic [N-1:0] v);
      return {v[N-1], v};
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= LOAD;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         LOAD:    next_state_s = RUN;
         RUN:     next_state_s = last_step_s ? DONE : RUN;
         DONE:    next_state_s = DONE;
         default: next_state_s = LOAD;
      endcase
   end

   // Step arithmetic: the final step subtracts M to weight the multiplier sign bit negatively
   always_comb begin
      last_step_s = (count_r == CW'(N - 1));
      if (q_r[0]) begin
         if (last_step_s) begin
            sum_s = sext(a_r) - sext(m_r);
         end else begin
            sum_s = sext(a_r) + sext(m_r);
         end
      end else begin
         sum_s = sext(a_r);
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_r       <= '0;
         q_r       <= '0;
         m_r       <= '0;
         count_r   <= '0;
         product_r <= '0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            LOAD: begin
               m_r     <= multiplicand;
               q_r     <= multiplier;
               a_r     <= '0;
               count_r <= '0;
            end
            RUN: begin
               a_r     <= sum_s[N:1];
               q_r     <= {sum_s[0], q_r[N-1:1]};
               count_r <= count_r + CW'(1);
               if (last_step_s) begin
                  product_r <= {sum_s[N:1], sum_s[0], q_r[N-1:1]};
                  done_r    <= 1'b1;
               end else begin
                  product_r <= product_r;
                  done_r    <= done_r;
               end
            end
            DONE: begin
               product_r <= product_r;
               done_r    <= done_r;
            end
            default: begin
               product_r <= '0;
               done_r    <= 1'b0;
            end
         endcase
      end
   end

   assign product = product_r;
   assign done    = done_r;

endmodule

// File: tb/tb_top_robertsons.sv
// Directed bench for top_robertsons: signed products, latency, hold and mid-run reset abort.
module tb_top_robertsons;

   logic        clk;
   logic        reset;
   logic [7:0]  multiplier;
   logic [7:0]  multiplicand;
   logic [15:0] product;
   logic        done;

   int errors = 0;
   int checks = 0;

   top_robertsons #(.N(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .product      (product),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reset pulse with operands applied, then release just after a falling edge
   task automatic start(input logic [7:0] q, input logic [7:0] m);
      @(negedge clk);
      multiplier   = q;
      multiplicand = m;
      reset        = 1'b0;
      #2;
      chk("rst_done", {15'd0, done}, 16'h0000);
      chk("rst_product", product, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Full multiply; with latency set, checks done/product stay low on edges 1..8
   task automatic run_mul(input string tag, input logic [7:0] q, input logic [7:0] m,
                          input logic [15:0] exp, input bit latency);
      start(q, m);
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         if (latency) begin
            chk($sformatf("%s_done_e%0d", tag, e), {15'd0, done}, 16'h0000);
            chk($sformatf("%s_prod_e%0d", tag, e), product, 16'h0000);
         end
      end
      @(posedge clk);
      #1;
      chk({tag, "_done"}, {15'd0, done}, 16'h0001);
      chk({tag, "_product"}, product, exp);
   endtask

   initial begin
      reset        = 1'b0;
      multiplier   = 8'h00;
      multiplicand = 8'h00;

      run_mul("p5x6",      8'h05, 8'h06, 16'h001E, 1'b1);
      run_mul("p5xm6",     8'h05, 8'hFA, 16'hFFE2, 1'b0);
      run_mul("m7x8",      8'hF9, 8'h08, 16'hFFC8, 1'b0);
      run_mul("m5xm6",     8'hFB, 8'hFA, 16'h001E, 1'b0);
      run_mul("m9xm4",     8'hF7, 8'hFC, 16'h0024, 1'b0);
      run_mul("m128xm128", 8'h80, 8'h80, 16'h4000, 1'b0);
      run_mul("m128x127",  8'h80, 8'h7F, 16'hC080, 1'b0);
      run_mul("p127x127",  8'h7F, 8'h7F, 16'h3F01, 1'b0);
      run_mul("p1xm128",   8'h01, 8'h80, 16'hFF80, 1'b0);
      run_mul("z0xm1",     8'h00, 8'hFF, 16'h0000, 1'b1);

      // Operand changes after done must not disturb the held result
      run_mul("p3xm2",     8'h03, 8'hFE, 16'hFFFA, 1'b0);
      multiplier   = 8'h7F;
      multiplicand = 8'h80;
      repeat (4) @(posedge clk);
      #1;
      chk("hold_done", {15'd0, done}, 16'h0001);
      chk("hold_product", product, 16'hFFFA);

      // Abort a 7 x 5 run at edge 4: outputs clear asynchronously
      start(8'h07, 8'h05);
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_done", {15'd0, done}, 16'h0000);
      chk("abort_product", product, 16'h0000);
      run_mul("p7x5", 8'h07, 8'h05, 16'h0023, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
